fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
Instruction fetch stage that sits directly upstream of the decode/control stage of the RV32I pipeline. It holds the fetch PC and issues single-outstanding reads to the instruction memory port. Returned instructions are buffered in a small in-order queue. The queue head is presented to decode with the opcode, funct3, funct7 and rd fields pre-sliced, so they feed the control-word generator directly. Branch/jump redirects from execute flush the queue and any in-flight fetch.

Parameters:
DEPTH, 4, queue entries; power of two, minimum 2
RESET_PC, 32'h00000060, fetch PC loaded on reset

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-high reset
imem_read  output  1  instruction read request
imem_address  output  32  read address (word aligned)
imem_resp  input  1  read data valid this cycle (may assert in the same cycle as the request)
imem_rdata  input  32  instruction word
redirect  input  1  flush and restart fetch (taken branch/jal/jalr)
redirect_pc  input  32  new fetch PC; bits [1:0] ignored, forced 0
deq_ready  input  1  decode accepts head this cycle
deq_valid  output  1  head entry valid
deq_pc  output  32  PC of head instruction
deq_instr  output  32  head instruction word
deq_opcode  output  7  deq_instr[6:0], typed rv32i_opcode
deq_funct3  output  3  deq_instr[14:12]
deq_funct7  output  7  deq_instr[31:25]
deq_rd  output  5  deq_instr[11:7]

Behaviour:
- State: fetch_pc (32b), circular buffer of DEPTH {pc, instr}, head/tail pointers (log2 DEPTH bits, wrap mod DEPTH), count (0..DEPTH), FSM {FETCH, DISCARD}.
- Reset (async, while rst=1): fetch_pc=RESET_PC, count=0, head=tail=0, FSM=FETCH. imem_read=0 and deq_valid=0 while rst is high.
- imem_address = fetch_pc at all times.
- FETCH state: imem_read = (count < DEPTH). Once asserted, imem_read and imem_address are held stable until imem_resp.
- On imem_resp in FETCH without redirect:
  - Write {fetch_pc, imem_rdata} at tail; tail++.
  - fetch_pc += 4; 32-bit wrap, so 0xFFFFFFFC goes to 0.
  - The next request may issue in the following cycle, giving 1 instr/cycle when resp is same-cycle.
- Single outstanding request only; because issue requires count < DEPTH, overflow is impossible.
- Dequeue: deq_valid = (count != 0) && !redirect; outputs are driven combinationally from the head entry. A handshake (deq_valid && deq_ready) advances head at the edge.
- Simultaneous enqueue and dequeue: count is unchanged and both pointers advance.
- Redirect (highest priority, takes effect at the edge):
  - head=tail=0, count=0; any same-cycle enqueue or dequeue is discarded; fetch_pc = {redirect_pc[31:2], 2'b00}.
  - If a request is outstanding (imem_read=1 and imem_resp=0): go to DISCARD. In DISCARD, imem_read stays 1 and imem_address stays at the old fetch_pc; fetch_pc is held in a shadow register until resp.
  - On resp in DISCARD: data is dropped, fetch_pc loads the redirect target, and the FSM returns to FETCH.
  - Redirect in the same cycle as imem_resp: the response is dropped, there is no DISCARD, and fetching restarts from redirect_pc next cycle.
  - Redirect during DISCARD: the pending target is replaced by the newer redirect_pc; the FSM stays in DISCARD.
- Reset mid-transaction: the outstanding request is abandoned; imem_read drops immediately (async).

Test Plan:
- Reset, then imem_resp tied to imem_read, deq_ready=1 -> addresses 0x60, 0x64, 0x68 on consecutive cycles; deq_pc follows one cycle behind; deq_opcode = imem_rdata[6:0].
- deq_ready=0, always-resp memory -> exactly 4 fetches (0x60–0x6C), then imem_read=0. Raise deq_ready for 1 cycle -> one fetch of 0x70 issued; head order preserved through pointer wrap.
- Queue holds 2 entries, redirect=1 with redirect_pc=0x103 and no outstanding request -> deq_valid=0 that cycle; next cycle imem_address=0x100 and count=0.
- Memory with 3-cycle latency; redirect to 0x200 one cycle after request 0x80 -> imem_read held at 0x80 until resp, data not enqueued, next request at 0x200.
- redirect and imem_resp in the same cycle -> response dropped, next address = redirect_pc, deq_valid stays 0.
- Redirect to 0xFFFFFFFC -> next fetch at 0x00000000; assert rst mid-request -> imem_read falls immediately, restarts at 0x60.

Source files
------------

// File: rtl/fetch_queue.sv
// RV32I instruction fetch stage: issues single-outstanding imem reads and buffers
// returned instructions in an in-order queue whose head feeds decode pre-sliced.
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0060
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_read,
    output logic [31:0] imem_address,
    input  logic        imem_resp,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        deq_ready,
    output logic        deq_valid,
    output logic [31:0] deq_pc,
    output logic [31:0] deq_instr,
    output logic [6:0]  deq_opcode,
    output logic [2:0]  deq_funct3,
    output logic [6:0]  deq_funct7,
    output logic [4:0]  deq_rd
);

    localparam int                PTR_W = $clog2(DEPTH);
    localparam int                CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0]  FULL  = CNT_W'(DEPTH);

    typedef enum logic {FETCH, DISCARD} state_t;

    state_t             state_q, state_d;
    logic [31:0]        fetch_pc_q, fetch_pc_d;
    logic [31:0]        target_q, target_d;
    logic [PTR_W-1:0]   head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [31:0]        pc_mem_q    [DEPTH];
    logic [31:0]        instr_mem_q [DEPTH];
    logic               enq, deq;
    logic [31:0]        redirect_aligned;

    assign redirect_aligned = redirect_pc & 32'hFFFF_FFFC;
    assign imem_address     = fetch_pc_q;

    // Both handshake outputs are gated by rst so they drop the instant reset rises.
    assign imem_read = !rst && ((state_q == DISCARD) || (count_q < FULL));
    assign deq_valid = !rst && (count_q != '0) && !redirect;

    assign deq_pc     = pc_mem_q[head_q];
    assign deq_instr  = instr_mem_q[head_q];
    assign deq_opcode = deq_instr[6:0];
    assign deq_funct3 = deq_instr[14:12];
    assign deq_funct7 = deq_instr[31:25];
    assign deq_rd     = deq_instr[11:7];

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        target_d   = target_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        enq        = 1'b0;
        deq        = 1'b0;
        case (state_q)
            FETCH: begin
                if (redirect) begin
                    head_d  = '0;
                    tail_d  = '0;
                    count_d = '0;
                    // An unanswered request must complete before the new PC can be presented.
                    if (imem_read && !imem_resp) begin
                        state_d  = DISCARD;
                        target_d = redirect_aligned;
                    end else begin
                        fetch_pc_d = redirect_aligned;
                    end
                end else begin
                    enq = imem_read && imem_resp;
                    deq = deq_valid && deq_ready;
                    if (enq) begin
                        tail_d     = tail_q + PTR_W'(1);
                        fetch_pc_d = fetch_pc_q + 32'd4;
                    end
                    if (deq) begin
                        head_d = head_q + PTR_W'(1);
                    end
                    if (enq && !deq) begin
                        count_d = count_q + CNT_W'(1);
                    end else if (deq && !enq) begin
                        count_d = count_q - CNT_W'(1);
                    end
                end
            end
            DISCARD: begin
                if (redirect) begin
                    target_d = redirect_aligned;
                end
                if (imem_resp) begin
                    state_d    = FETCH;
                    fetch_pc_d = redirect ? redirect_aligned : target_q;
                end
            end
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= FETCH;
            fetch_pc_q <= RESET_PC;
            target_q   <= RESET_PC;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            target_q   <= target_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            pc_mem_q[tail_q]    <= fetch_pc_q;
            instr_mem_q[tail_q] <= imem_rdata;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Randomized bench for fetch_queue: a queue-based reference model tracks what the
// fetch stage should present each cycle against a variable-latency memory.
module tb_fetch_queue;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst;
    logic        imem_read;
    logic [31:0] imem_address;
    logic        imem_resp;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        deq_ready;
    logic        deq_valid;
    logic [31:0] deq_pc;
    logic [31:0] deq_instr;
    logic [6:0]  deq_opcode;
    logic [2:0]  deq_funct3;
    logic [6:0]  deq_funct7;
    logic [4:0]  deq_rd;

    fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0060)) dut (
        .clk(clk), .rst(rst),
        .imem_read(imem_read), .imem_address(imem_address),
        .imem_resp(imem_resp), .imem_rdata(imem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .deq_ready(deq_ready), .deq_valid(deq_valid),
        .deq_pc(deq_pc), .deq_instr(deq_instr),
        .deq_opcode(deq_opcode), .deq_funct3(deq_funct3),
        .deq_funct7(deq_funct7), .deq_rd(deq_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: entries are {pc, instr}; discarding/target model a flushed in-flight read.
    logic [63:0] modelQ[$];
    logic [31:0] modelPc;
    logic        discarding;
    logic [31:0] pendingTarget;
    logic        reqActive;
    int          lat;
    int          minLat;
    int          maxLat;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic modelReset();
        modelQ.delete();
        modelPc       = 32'h0000_0060;
        discarding    = 1'b0;
        pendingTarget = 32'h0;
        reqActive     = 1'b0;
        lat           = 0;
    endtask

    // One clock cycle: drive inputs, check combinational view, advance model to the next edge.
    task automatic applyStimulus(input logic redir, input logic [31:0] rpc, input logic ready);
        logic        expRead;
        logic        expValid;
        logic        resp;
        logic [31:0] rdata;
        logic [31:0] target;
        logic [63:0] head;
        logic [31:0] headInstr;
        @(negedge clk);
        expRead = discarding ? 1'b1 : (modelQ.size() < DEPTH);
        if (expRead && !reqActive) begin
            reqActive = 1'b1;
            lat       = int'($urandom_range(minLat, maxLat));
        end
        resp        = expRead && (lat == 0);
        rdata       = $urandom;
        redirect    = redir;
        redirect_pc = rpc;
        deq_ready   = ready;
        imem_resp   = resp;
        imem_rdata  = rdata;
        #1;
        expValid = (modelQ.size() != 0) && !redir;
        checkOutput("imem_read", {31'b0, imem_read}, {31'b0, expRead});
        checkOutput("imem_address", imem_address, modelPc);
        checkOutput("deq_valid", {31'b0, deq_valid}, {31'b0, expValid});
        if (expValid) begin
            head      = modelQ[0];
            headInstr = head[31:0];
            checkOutput("deq_pc", deq_pc, head[63:32]);
            checkOutput("deq_instr", deq_instr, headInstr);
            checkOutput("deq_opcode", {25'b0, deq_opcode}, {25'b0, headInstr[6:0]});
            checkOutput("deq_funct3", {29'b0, deq_funct3}, {29'b0, headInstr[14:12]});
            checkOutput("deq_funct7", {25'b0, deq_funct7}, {25'b0, headInstr[31:25]});
            checkOutput("deq_rd", {27'b0, deq_rd}, {27'b0, headInstr[11:7]});
        end
        target = {rpc[31:2], 2'b00};
        if (redir) begin
            modelQ.delete();
            if (discarding) begin
                pendingTarget = target;
                if (resp) begin
                    modelPc    = target;
                    discarding = 1'b0;
                end
            end else if (expRead && !resp) begin
                discarding    = 1'b1;
                pendingTarget = target;
            end else begin
                modelPc = target;
            end
        end else if (discarding) begin
            if (resp) begin
                modelPc    = pendingTarget;
                discarding = 1'b0;
            end
        end else begin
            if (expValid && ready) void'(modelQ.pop_front());
            if (expRead && resp) begin
                modelQ.push_back({modelPc, rdata});
                modelPc = modelPc + 32'd4;
            end
        end
        if (expRead) begin
            if (resp) reqActive = 1'b0;
            else      lat--;
        end
        @(posedge clk);
    endtask

    initial begin
        rst         = 1'b1;
        imem_resp   = 1'b0;
        imem_rdata  = 32'h0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        deq_ready   = 1'b0;
        minLat      = 0;
        maxLat      = 0;
        modelReset();
        #12;
        checkOutput("reset_read", {31'b0, imem_read}, 32'h0);
        checkOutput("reset_valid", {31'b0, deq_valid}, 32'h0);
        checkOutput("reset_address", imem_address, 32'h0000_0060);
        @(negedge clk);
        rst = 1'b0;

        // Back-to-back fetch with a same-cycle memory and decode always ready.
        repeat (10) applyStimulus(1'b0, 32'h0, 1'b1);

        // Fill the queue, then let one slot free and drain through pointer wrap.
        repeat (8) applyStimulus(1'b0, 32'h0, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b1);
        repeat (4) applyStimulus(1'b0, 32'h0, 1'b0);
        repeat (8) applyStimulus(1'b0, 32'h0, 1'b1);

        // Redirect with a misaligned target onto a partly-filled queue.
        repeat (2) applyStimulus(1'b0, 32'h0, 1'b0);
        applyStimulus(1'b1, 32'h0000_0103, 1'b1);
        repeat (4) applyStimulus(1'b0, 32'h0, 1'b1);

        // Slow memory: redirect while a read is outstanding forces a discard.
        minLat = 3;
        maxLat = 3;
        applyStimulus(1'b0, 32'h0, 1'b1);
        applyStimulus(1'b1, 32'h0000_0200, 1'b1);
        applyStimulus(1'b1, 32'h0000_0300, 1'b1);
        repeat (10) applyStimulus(1'b0, 32'h0, 1'b1);

        // Redirect near the top of the address space to exercise PC wrap.
        minLat = 0;
        maxLat = 0;
        applyStimulus(1'b1, 32'hFFFF_FFFE, 1'b1);
        repeat (5) applyStimulus(1'b0, 32'h0, 1'b1);

        // Randomized traffic mixing latencies, backpressure and redirects.
        for (int i = 0; i < 3000; i++) begin
            if (i % 100 == 0) begin
                minLat = 0;
                maxLat = int'($urandom_range(0, 3));
            end
            applyStimulus(($urandom_range(0, 9) == 0), $urandom, ($urandom_range(0, 1) == 1));
        end

        // Reset asserted while a slow read is still pending.
        minLat = 3;
        maxLat = 3;
        repeat (2) applyStimulus(1'b0, 32'h0, 1'b0);
        @(negedge clk);
        imem_resp = 1'b0;
        redirect  = 1'b0;
        #2 rst = 1'b1;
        #1;
        checkOutput("midreset_read", {31'b0, imem_read}, 32'h0);
        checkOutput("midreset_valid", {31'b0, deq_valid}, 32'h0);
        checkOutput("midreset_address", imem_address, 32'h0000_0060);
        @(posedge clk);
        #1;
        checkOutput("midreset_read_held", {31'b0, imem_read}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        modelReset();
        minLat = 0;
        maxLat = 2;
        repeat (20) applyStimulus(1'b0, 32'h0, ($urandom_range(0, 1) == 1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
